// File: rtl/irq_rr_arbiter.sv
// Round-robin interrupt arbiter: grants one requester at a time on the shared
// interrupt-service channel, drives the channel mux code, waits for service
// completion or a timeout, then releases and rotates priority.
module irq_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 12,
  parameter int CNT_W   = 4,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic [1:0]      cc_mux,
  output logic            enable_count,
  output logic            timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] CC_IDLE  = 2'b00;
  localparam logic [1:0] CC_ENIN  = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [IDW-1:0]   ID_LAST  = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDW-1:0]   last_id, last_id_n;
  logic [NREQ-1:0]  grant_n;
  logic [IDW-1:0]   grant_id_n;
  logic             busy_n;
  logic [1:0]       cc_mux_n;
  logic             enable_count_n;
  logic             timeout_n;

  logic [IDW-1:0]   sel;
  logic             found;
  int               idx;

  // Rotating priority search: first set request starting just after last_id
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last_id) + 1 + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  // Next-state and next-output logic; every register holds unless changed
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    last_id_n      = last_id;
    grant_n        = grant;
    grant_id_n     = grant_id;
    busy_n         = busy;
    cc_mux_n       = cc_mux;
    enable_count_n = enable_count;
    timeout_n      = timeout;

    case (state)
      S_IDLE: begin
        cc_mux_n = CC_IDLE;
        if (found) begin
          grant_n    = ONE_HOT0 << sel;
          grant_id_n = sel;
          busy_n     = 1'b1;
          cc_mux_n   = CC_INTR;
          state_n    = S_GRANT;
        end
      end
      S_GRANT: begin
        cc_mux_n       = CC_ACKIN;
        cnt_n          = '0;
        enable_count_n = 1'b1;
        state_n        = S_WAIT;
      end
      S_WAIT: begin
        cnt_n = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
        if (done || (cnt == CNT_LAST)) begin
          // done wins over a simultaneous timeout
          timeout_n      = ~done;
          enable_count_n = 1'b0;
          grant_n        = '0;
          cc_mux_n       = CC_ENIN;
          state_n        = S_RELEASE;
        end
      end
      S_RELEASE: begin
        last_id_n = grant_id;
        busy_n    = 1'b0;
        timeout_n = 1'b0;
        cc_mux_n  = CC_IDLE;
        state_n   = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last_id      <= ID_LAST;
      grant        <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      cc_mux       <= CC_IDLE;
      enable_count <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      last_id      <= last_id_n;
      grant        <= grant_n;
      grant_id     <= grant_id_n;
      busy         <= busy_n;
      cc_mux       <= cc_mux_n;
      enable_count <= enable_count_n;
      timeout      <= timeout_n;
    end
  end

endmodule
